// File: rtl/barvinn_top.sv
// Glue between the pito barrel processor and the MVU array: decodes per-hart CSR
// accesses into MVU configuration writes and job starts, and tracks job completion.
module barvinn_top #(
  parameter int NUM_HARTS = 8,
  parameter int XLEN      = 32,
  parameter int NUM_CFG   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_we,
  input  logic                 csr_re,
  input  logic [2:0]           csr_hart,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_rvalid,
  output logic [NUM_HARTS-1:0] mvu_cfg_we,
  output logic [3:0]           mvu_cfg_addr,
  output logic [XLEN-1:0]      mvu_cfg_wdata,
  output logic [NUM_HARTS-1:0] mvu_start,
  input  logic [NUM_HARTS-1:0] mvu_done,
  output logic [NUM_HARTS-1:0] hart_irq
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_BUSY     = 1'b1;
  localparam logic [7:0]  ADDR_CFG_HI = 8'hF2;
  localparam logic [11:0] ADDR_CMD    = 12'hF30;
  localparam logic [11:0] ADDR_STATUS = 12'hF31;
  localparam logic [11:0] ADDR_ACK    = 12'hF32;

  logic [NUM_HARTS-1:0][NUM_CFG-1:0][XLEN-1:0] cfg_q, cfg_d;
  logic [NUM_HARTS-1:0] state_q, state_d;
  logic [NUM_HARTS-1:0] done_q, done_d;
  logic [NUM_HARTS-1:0] err_q, err_d;
  logic [NUM_HARTS-1:0] start_q, start_d;
  logic [NUM_HARTS-1:0] cfg_we_q, cfg_we_d;
  logic [3:0]           cfg_addr_q, cfg_addr_d;
  logic [XLEN-1:0]      cfg_wdata_q, cfg_wdata_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic [NUM_HARTS-1:0] hart_oh;
  logic                 cfg_hit;
  logic                 cmd_hit;
  logic                 ack_hit;
  logic [NUM_HARTS-1:0] st_after_done;

  always_comb begin
    hart_oh = NUM_HARTS'(1) << csr_hart;
    cfg_hit = csr_we && (csr_addr[11:4] == ADDR_CFG_HI);
    cmd_hit = csr_we && (csr_addr == ADDR_CMD);
    ack_hit = csr_we && (csr_addr == ADDR_ACK);

    cfg_d       = cfg_q;
    cfg_we_d    = '0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    if (cfg_hit) begin
      cfg_d[csr_hart][csr_addr[3:0]] = csr_wdata;
      cfg_we_d    = hart_oh;
      cfg_addr_d  = csr_addr[3:0];
      cfg_wdata_d = csr_wdata;
    end

    // Reads sample the registers before this cycle's write lands.
    rvalid_d = csr_re;
    rdata_d  = '0;
    if (csr_re) begin
      if (csr_addr[11:4] == ADDR_CFG_HI) begin
        rdata_d = cfg_q[csr_hart][csr_addr[3:0]];
      end else if (csr_addr == ADDR_STATUS) begin
        rdata_d = {{(XLEN-3){1'b0}}, err_q[csr_hart], done_q[csr_hart], state_q[csr_hart]};
      end
    end

    state_d       = state_q;
    done_d        = done_q;
    err_d         = err_q;
    start_d       = '0;
    st_after_done = state_q;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (ack_hit && hart_oh[i]) begin
        done_d[i] = 1'b0;
        err_d[i]  = 1'b0;
      end
      // Completion is handled before any command so a same-cycle command restarts the MVU.
      if (state_q[i] == ST_BUSY && mvu_done[i]) begin
        st_after_done[i] = ST_IDLE;
        done_d[i]        = 1'b1;
      end
      state_d[i] = st_after_done[i];
      if (cmd_hit && hart_oh[i]) begin
        if (st_after_done[i] == ST_IDLE) begin
          start_d[i] = 1'b1;
          state_d[i] = ST_BUSY;
        end else begin
          err_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q       <= '0;
      state_q     <= {NUM_HARTS{ST_IDLE}};
      done_q      <= '0;
      err_q       <= '0;
      start_q     <= '0;
      cfg_we_q    <= '0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // The interrupt is exactly the sticky done flag, so it shares its flop.
  assign hart_irq      = done_q;
  assign mvu_start     = start_q;
  assign mvu_cfg_we    = cfg_we_q;
  assign mvu_cfg_addr  = cfg_addr_q;
  assign mvu_cfg_wdata = cfg_wdata_q;
  assign csr_rdata     = rdata_q;
  assign csr_rvalid    = rvalid_q;

endmodule

// File: tb/tb_barvinn_top.sv
// Directed self-checking bench for barvinn_top: CSR decode, job lifecycle,
// same-cycle priority cases and reset behaviour.
module tb_barvinn_top;

  logic        clk;
  logic        rst;
  logic        csr_we;
  logic        csr_re;
  logic [2:0]  csr_hart;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic [7:0]  mvu_cfg_we;
  logic [3:0]  mvu_cfg_addr;
  logic [31:0] mvu_cfg_wdata;
  logic [7:0]  mvu_start;
  logic [7:0]  mvu_done;
  logic [7:0]  hart_irq;

  int checks;
  int errors;
  int start5_cnt;

  barvinn_top dut (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_re       (csr_re),
    .csr_hart     (csr_hart),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_rvalid   (csr_rvalid),
    .mvu_cfg_we   (mvu_cfg_we),
    .mvu_cfg_addr (mvu_cfg_addr),
    .mvu_cfg_wdata(mvu_cfg_wdata),
    .mvu_start    (mvu_start),
    .mvu_done     (mvu_done),
    .hart_irq     (hart_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) start5_cnt <= 0;
    else if (mvu_start[5]) start5_cnt <= start5_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns 1ns after the edge with inputs idle.
  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] hart,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [7:0] done);
    csr_we    = we;
    csr_re    = re;
    csr_hart  = hart;
    csr_addr  = addr;
    csr_wdata = wdata;
    mvu_done  = done;
    @(posedge clk);
    #1;
    csr_we    = 1'b0;
    csr_re    = 1'b0;
    csr_hart  = 3'd0;
    csr_addr  = 12'h000;
    csr_wdata = 32'h0;
    mvu_done  = 8'h00;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] hart, input logic [11:0] addr,
                           input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, hart, addr, 32'h0, 8'h00);
    checkOutput({tag, "_vld"}, {31'b0, csr_rvalid}, 32'h1);
    checkOutput(tag, csr_rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    csr_we = 1'b0;
    csr_re = 1'b0;
    csr_hart = 3'd0;
    csr_addr = 12'h000;
    csr_wdata = 32'h0;
    mvu_done = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_irq", {24'b0, hart_irq}, 32'h0);
    checkOutput("rst_start", {24'b0, mvu_start}, 32'h0);
    checkOutput("rst_cfgwe", {24'b0, mvu_cfg_we}, 32'h0);
    checkOutput("rst_rvalid", {31'b0, csr_rvalid}, 32'h0);
    checkOutput("rst_rdata", csr_rdata, 32'h0);
    for (int h = 0; h < 8; h++) readCheck("rst_status", 3'(h), 12'hF31, 32'h0);

    $display("[TB] config path");
    applyStimulus(1'b1, 1'b0, 3'd3, 12'hF25, 32'hDEADBEEF, 8'h00);
    checkOutput("cfg_we", {24'b0, mvu_cfg_we}, 32'h08);
    checkOutput("cfg_addr", {28'b0, mvu_cfg_addr}, 32'h5);
    checkOutput("cfg_wdata", mvu_cfg_wdata, 32'hDEADBEEF);
    idle(1);
    checkOutput("cfg_we_drop", {24'b0, mvu_cfg_we}, 32'h0);
    readCheck("cfg_rb_h3", 3'd3, 12'hF25, 32'hDEADBEEF);
    readCheck("cfg_rb_h2", 3'd2, 12'hF25, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd4, 12'hF21, 32'h00001234, 8'h00);
    checkOutput("rw_same_old", csr_rdata, 32'h0);
    readCheck("rw_same_new", 3'd4, 12'hF21, 32'h00001234);
    readCheck("unmapped_rd", 3'd0, 12'h123, 32'h0);

    $display("[TB] job lifecycle");
    applyStimulus(1'b1, 1'b0, 3'd0, 12'hF30, 32'hFFFFFFFF, 8'h00);
    checkOutput("job_start", {24'b0, mvu_start}, 32'h01);
    readCheck("job_busy", 3'd0, 12'hF31, 32'h1);
    checkOutput("job_start_drop", {24'b0, mvu_start}, 32'h0);
    checkOutput("job_irq_low", {24'b0, hart_irq}, 32'h0);
    idle(8);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h01);
    checkOutput("job_irq", {24'b0, hart_irq}, 32'h01);
    readCheck("job_done", 3'd0, 12'hF31, 32'h2);
    applyStimulus(1'b1, 1'b0, 3'd0, 12'hF32, 32'h0, 8'h00);
    checkOutput("job_ack_irq", {24'b0, hart_irq}, 32'h0);
    readCheck("job_ack_status", 3'd0, 12'hF31, 32'h0);

    $display("[TB] busy overlap");
    applyStimulus(1'b1, 1'b0, 3'd5, 12'hF30, 32'h0, 8'h00);
    idle(2);
    applyStimulus(1'b1, 1'b0, 3'd5, 12'hF30, 32'h0, 8'h00);
    idle(2);
    checkOutput("overlap_starts", start5_cnt, 32'd1);
    readCheck("overlap_status", 3'd5, 12'hF31, 32'h5);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h20);
    applyStimulus(1'b1, 1'b0, 3'd5, 12'hF32, 32'h0, 8'h00);
    readCheck("overlap_clear", 3'd5, 12'hF31, 32'h0);

    $display("[TB] simultaneous events");
    applyStimulus(1'b1, 1'b0, 3'd7, 12'hF30, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd7, 12'hF32, 32'h0, 8'h80);
    checkOutput("done_vs_ack_irq", {24'b0, hart_irq}, 32'h80);
    readCheck("done_vs_ack_status", 3'd7, 12'hF31, 32'h2);
    applyStimulus(1'b1, 1'b0, 3'd7, 12'hF32, 32'h0, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h02);
    checkOutput("spurious_irq", {24'b0, hart_irq}, 32'h0);
    readCheck("spurious_status", 3'd1, 12'hF31, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd6, 12'hF30, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd6, 12'hF30, 32'h0, 8'h40);
    checkOutput("done_vs_cmd_start", {24'b0, mvu_start}, 32'h40);
    readCheck("done_vs_cmd_status", 3'd6, 12'hF31, 32'h3);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h40);
    applyStimulus(1'b1, 1'b0, 3'd6, 12'hF32, 32'h0, 8'h00);
    checkOutput("pre_parallel_irq", {24'b0, hart_irq}, 32'h0);

    $display("[TB] parallel harts");
    for (int h = 0; h < 8; h++) applyStimulus(1'b1, 1'b0, 3'(h), 12'hF30, 32'h0, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'hFF);
    checkOutput("parallel_irq", {24'b0, hart_irq}, 32'hFF);
    for (int h = 0; h < 8; h++) readCheck("parallel_status", 3'(h), 12'hF31, 32'h2);

    $display("[TB] reset mid-job");
    applyStimulus(1'b1, 1'b0, 3'd0, 12'hF32, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 12'hF30, 32'h0, 8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("midrst_irq", {24'b0, hart_irq}, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 32'h0, 8'h01);
    checkOutput("midrst_spurious_irq", {24'b0, hart_irq}, 32'h0);
    readCheck("midrst_status", 3'd0, 12'hF31, 32'h0);
    readCheck("midrst_cfg", 3'd3, 12'hF25, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
